// File: rtl/game_pkg.sv
// Shared game definitions: attack type and attack state codes used by the issuer
// and by game mechanics, plus the issuer FSM states.
package game_pkg;

  typedef enum logic [3:0] {
    STANDBY = 4'b0000,
    LIGHT   = 4'b0001,
    HEAVY   = 4'b0010
  } attack_type_e;

  typedef enum logic [1:0] {
    NO_HIT   = 2'd0,
    CRITICAL = 2'd1,
    NORMAL   = 2'd2,
    MISS     = 2'd3
  } attack_state_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    COOLDOWN = 2'd2
  } issuer_state_e;

  // Combine a held/first press with a newer one: the held type wins unless HEAVY arrives.
  function automatic attack_type_e merge_press(input attack_type_e held,
                                               input attack_type_e incoming);
    if (held == STANDBY) return incoming;
    if (incoming == HEAVY) return HEAVY;
    return held;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button to one-cycle press pulse: 2-flop synchronizer, level debouncer
// and rising-edge detect on the debounced level.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((DEBOUNCE_CYCLES < 2) ? 0 : DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync;
  logic             level;
  logic [CNT_W-1:0] cnt;

  // cnt counts consecutive cycles the synchronized value disagrees with level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], btn};
      press <= 1'b0;
      if (sync[1] != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync[1];
          press <= sync[1];
          cnt   <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/attack_issuer.sv
// Turns debounced light/heavy button presses into one-cycle attack issues with a
// per-type cooldown. Define ATTACK_QUEUE_EN to hold one press made during cooldown.
module attack_issuer #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned LIGHT_COOLDOWN  = 8,
  parameter int unsigned HEAVY_COOLDOWN  = 16
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_btn_light,
  input  logic       i_btn_heavy,
  input  logic       i_game_active,
  output logic [3:0] o_types,
  output logic       o_busy,
  output logic [7:0] o_attack_count
);
  import game_pkg::*;

  localparam int unsigned CD_MAX = (LIGHT_COOLDOWN > HEAVY_COOLDOWN) ? LIGHT_COOLDOWN
                                                                     : HEAVY_COOLDOWN;
  localparam int unsigned CD_W = (CD_MAX < 2) ? 1 : $clog2(CD_MAX + 1);
  localparam logic [CD_W-1:0] LIGHT_CD = CD_W'(LIGHT_COOLDOWN);
  localparam logic [CD_W-1:0] HEAVY_CD = CD_W'(HEAVY_COOLDOWN);

  logic [1:0]    rst_pipe;
  logic          rst_n;
  logic          press_light;
  logic          press_heavy;
  attack_type_e  press_type_c;
  logic [CD_W-1:0] cd_load_c;
  issuer_state_e state;
  logic [CD_W-1:0] cd_cnt;

  // Assert asynchronously, release on a clock edge
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) rst_pipe <= '0;
    else          rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_n = rst_pipe[1];

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_light (
    .clk   (i_clk),
    .rst_n (rst_n),
    .btn   (i_btn_light),
    .press (press_light)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_heavy (
    .clk   (i_clk),
    .rst_n (rst_n),
    .btn   (i_btn_heavy),
    .press (press_heavy)
  );

  assign press_type_c = merge_press(press_light ? LIGHT : STANDBY,
                                    press_heavy ? HEAVY : STANDBY);
  assign cd_load_c    = (o_types == HEAVY) ? HEAVY_CD : LIGHT_CD;

`ifdef ATTACK_QUEUE_EN
  attack_type_e queued;
  attack_type_e queued_next_c;
  assign queued_next_c = merge_press(queued, press_type_c);
`endif

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      o_types        <= STANDBY;
      o_busy         <= 1'b0;
      o_attack_count <= '0;
      cd_cnt         <= '0;
`ifdef ATTACK_QUEUE_EN
      queued         <= STANDBY;
`endif
    end else if (!i_game_active) begin
      state   <= IDLE;
      o_types <= STANDBY;
      o_busy  <= 1'b0;
      cd_cnt  <= '0;
`ifdef ATTACK_QUEUE_EN
      queued  <= STANDBY;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (press_type_c != STANDBY) begin
            state          <= ISSUE;
            o_types        <= press_type_c;
            o_busy         <= 1'b1;
            o_attack_count <= o_attack_count + 8'd1;
          end
        end
        ISSUE: begin
          o_types <= STANDBY;
          if (cd_load_c == '0) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end else begin
            state  <= COOLDOWN;
            cd_cnt <= cd_load_c;
          end
        end
        COOLDOWN: begin
          if (cd_cnt > CD_W'(1)) begin
            cd_cnt <= cd_cnt - CD_W'(1);
`ifdef ATTACK_QUEUE_EN
            queued <= queued_next_c;
`endif
          end else begin
            cd_cnt <= '0;
`ifdef ATTACK_QUEUE_EN
            // A press held (or arriving) in the last cooldown cycle skips IDLE
            if (queued_next_c != STANDBY) begin
              state          <= ISSUE;
              o_types        <= queued_next_c;
              o_attack_count <= o_attack_count + 8'd1;
              queued         <= STANDBY;
            end else begin
              state  <= IDLE;
              o_busy <= 1'b0;
            end
`else
            state  <= IDLE;
            o_busy <= 1'b0;
`endif
          end
        end
        default: begin
          state   <= IDLE;
          o_types <= STANDBY;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_attack_issuer.sv
// Bench for attack_issuer: vector table, corner-case sequences and a random run
// against an issue-time reference model.
module tb_attack_issuer;

  localparam int DEB = 4;
  localparam int LCD = 8;
  localparam int HCD = 16;
`ifdef ATTACK_QUEUE_EN
  localparam int QUEUED = 1;
`else
  localparam int QUEUED = 0;
`endif

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_btn_light = 1'b0;
  logic       i_btn_heavy = 1'b0;
  logic       i_game_active = 1'b0;
  logic [3:0] o_types;
  logic       o_busy;
  logic [7:0] o_attack_count;

  int n_cmp = 0;
  int n_bad = 0;

  attack_issuer dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_btn_light    (i_btn_light),
    .i_btn_heavy    (i_btn_heavy),
    .i_game_active  (i_game_active),
    .o_types        (o_types),
    .o_busy         (o_busy),
    .o_attack_count (o_attack_count)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int ls; int ll; int hs; int hl;
    int exp_cyc; int exp_type; int exp_busy; int exp_cnt;
  } vec_t;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic do_reset();
    i_reset = 1'b0;
    i_btn_light = 1'b0;
    i_btn_heavy = 1'b0;
    i_game_active = 1'b1;
    @(negedge i_clk);
    check("reset o_types", o_types, 0);
    check("reset o_busy", o_busy, 0);
    check("reset o_attack_count", o_attack_count, 0);
    @(negedge i_clk);
    i_reset = 1'b1;
    repeat (6) tick();
  endtask

  function automatic bit deb_step(input bit s, inout bit lvl, inout int run);
    if (s == lvl) begin
      run = 0;
      return 1'b0;
    end
    run++;
    if (run < DEB) return 1'b0;
    lvl = s;
    run = 0;
    return s;
  endfunction

  function automatic int merge_ref(input int held, input int incoming);
    if (held == 0) return incoming;
    if (incoming == 2) return 2;
    return held;
  endfunction

  vec_t vecs[7];
  int first, ftype, busy_n, pulses, t7, t24, late;
  int last_iss, last_cd, last_type, m_cnt, pend, evt_prev, iss, exp_busy, exp_types;
  int run_l, run_h, hold_l, hold_h;
  bit lvl_l, lvl_h, rl, rh, cur_l, cur_h;
  logic [2:0] pl, ph;

  initial begin
    vecs[0] = '{0, 20, 0, 0, 7, 1, 9, 1};
    vecs[1] = '{0, 0, 0, 20, 7, 2, 17, 1};
    vecs[2] = '{0, 20, 0, 20, 7, 2, 17, 1};
    vecs[3] = '{0, 3, 0, 0, -1, 0, 0, 0};
    vecs[4] = '{0, 4, 0, 0, 7, 1, 9, 1};
    vecs[5] = '{0, 20, 1, 20, 7, 1, 9, 1};
    vecs[6] = '{10, 20, 0, 0, 17, 1, 9, 1};
    #1;

    for (int v = 0; v < 7; v++) begin
      first = -1; ftype = 0; busy_n = 0; pulses = 0;
      do_reset();
      for (int c = 0; c < 60; c++) begin
        if (o_types != 4'd0) begin
          pulses++;
          if (first < 0) begin first = c; ftype = int'(o_types); end
        end
        if (o_busy) busy_n++;
        i_btn_light = (c >= vecs[v].ls) && (c < vecs[v].ls + vecs[v].ll);
        i_btn_heavy = (c >= vecs[v].hs) && (c < vecs[v].hs + vecs[v].hl);
        tick();
      end
      check($sformatf("vec%0d issue_cycle", v), first, vecs[v].exp_cyc);
      check($sformatf("vec%0d type", v), ftype, vecs[v].exp_type);
      check($sformatf("vec%0d busy_cycles", v), busy_n, vecs[v].exp_busy);
      check($sformatf("vec%0d issues", v), pulses, vecs[v].exp_cnt);
      check($sformatf("vec%0d count", v), o_attack_count, vecs[v].exp_cnt);
    end

    // Light press three cycles into a heavy cooldown
    do_reset();
    t7 = -1; t24 = -1; pulses = 0;
    for (int c = 0; c < 60; c++) begin
      if (c == 7) t7 = int'(o_types);
      if (c == 24) t24 = int'(o_types);
      if (o_types != 4'd0) pulses++;
      i_btn_heavy = (c < 20);
      i_btn_light = (c >= 4) && (c <= 30);
      tick();
    end
    check("cdpress heavy_issue", t7, 2);
    check("cdpress after_cooldown", t24, QUEUED);
    check("cdpress issues", pulses, 1 + QUEUED);
    check("cdpress count", o_attack_count, 1 + QUEUED);

    // Match stopped mid-cooldown, button cycled while inactive, then restarted
    do_reset();
    late = 0;
    for (int c = 0; c < 71; c++) begin
      if (c == 12) check("gameoff busy_before", o_busy, 1);
      if (c == 13) begin
        check("gameoff busy", o_busy, 0);
        check("gameoff types", o_types, 0);
        check("gameoff count_held", o_attack_count, 1);
      end
      if (c >= 13 && o_types != 4'd0) late++;
      i_btn_light = (c < 14) || (c >= 20);
      i_game_active = !((c >= 12) && (c < 40));
      tick();
    end
    check("gameoff no_late_issue", late, 0);
    check("gameoff final_count", o_attack_count, 1);

    // Asynchronous reset in the ISSUE cycle
    do_reset();
    for (int c = 0; c < 7; c++) begin
      i_btn_light = (c < 20);
      tick();
    end
    check("rstmid issue", o_types, 1);
    #2 i_reset = 1'b0;
    #1;
    check("rstmid types", o_types, 0);
    check("rstmid busy", o_busy, 0);
    check("rstmid count", o_attack_count, 0);
    @(negedge i_clk);
    i_reset = 1'b1;

    // 256 issues wrap the counter
    do_reset();
    pulses = 0;
    for (int i = 0; i < 256; i++) begin
      for (int c = 0; c < 12; c++) begin
        if (o_types != 4'd0) pulses++;
        i_btn_light = (c < 6);
        tick();
      end
      if (i == 254) check("wrap count_255", o_attack_count, 255);
    end
    repeat (20) begin
      if (o_types != 4'd0) pulses++;
      tick();
    end
    check("wrap issues", pulses, 256);
    check("wrap count_0", o_attack_count, 0);

    // Random buttons against the issue-time model
    do_reset();
    last_iss = -1000; last_cd = 0; last_type = 0; m_cnt = 0; pend = 0; evt_prev = 0;
    run_l = 0; run_h = 0; lvl_l = 1'b0; lvl_h = 1'b0; pl = '0; ph = '0;
    cur_l = 1'b0; cur_h = 1'b0; hold_l = 3; hold_h = 7;
    for (int c = 0; c < 2500; c++) begin
      iss = 0;
`ifdef ATTACK_QUEUE_EN
      if ((c - 1 > last_iss) && (c - 1 <= last_iss + last_cd)) pend = merge_ref(pend, evt_prev);
      if (last_cd > 0 && c == last_iss + last_cd + 1 && pend != 0) begin
        iss = pend;
        pend = 0;
      end
`endif
      if (iss == 0 && evt_prev != 0 && c >= last_iss + last_cd + 2) iss = evt_prev;
      if (iss != 0) begin
        last_iss = c;
        last_type = iss;
        last_cd = (iss == 2) ? HCD : LCD;
        m_cnt = (m_cnt + 1) % 256;
      end
      rl = deb_step(pl[2], lvl_l, run_l);
      rh = deb_step(ph[2], lvl_h, run_h);
      evt_prev = rh ? 2 : (rl ? 1 : 0);
      exp_types = (c == last_iss) ? last_type : 0;
      exp_busy = (c >= last_iss && c <= last_iss + last_cd) ? 1 : 0;
      check($sformatf("rand c%0d types", c), o_types, exp_types);
      check($sformatf("rand c%0d busy", c), o_busy, exp_busy);
      check($sformatf("rand c%0d count", c), o_attack_count, m_cnt);
      if (hold_l == 0) begin cur_l = !cur_l; hold_l = $urandom_range(1, 12); end
      if (hold_h == 0) begin cur_h = !cur_h; hold_h = $urandom_range(1, 12); end
      hold_l--;
      hold_h--;
      i_btn_light = cur_l;
      i_btn_heavy = cur_h;
      pl = {pl[1:0], cur_l};
      ph = {ph[1:0], cur_h};
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/attack_issuer.md
ATTACK_ISSUER -- requirements
Module: attack_issuer

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning consecutive stable synchronized cycles required to accept a button level change.
REQ-002 The block SHALL have parameter LIGHT_COOLDOWN, default 8, meaning COOLDOWN cycles after a LIGHT issue.
REQ-003 The block SHALL have parameter HEAVY_COOLDOWN, default 16, meaning COOLDOWN cycles after a HEAVY issue.
REQ-004 The block SHALL have port i_clk, input, 1, sole clock, rising edge.
REQ-005 The block SHALL have port i_reset, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port i_btn_light, input, 1, raw asynchronous light-attack button, active-high.
REQ-007 The block SHALL have port i_btn_heavy, input, 1, raw asynchronous heavy-attack button, active-high.
REQ-008 The block SHALL have port i_game_active, input, 1, high while a match is running.
REQ-009 The block SHALL have port o_types, output, 4, attack type code consumed by game mechanics: STANDBY 4'b0000, LIGHT 4'b0001, HEAVY 4'b0010.
REQ-010 The block SHALL have port o_busy, output, 1, high during ISSUE and COOLDOWN.
REQ-011 The block SHALL have port o_attack_count, output, 8, number of attacks issued.

Function
REQ-012 Each button SHALL pass a 2-flop synchronizer, then a debouncer whose output level changes only after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive cycles.
REQ-013 A press event SHALL be the debounced rising edge; release and held levels SHALL generate no events.
REQ-014 The FSM SHALL have states IDLE, ISSUE, COOLDOWN.
REQ-015 IDLE: on a press event with i_game_active high, go to ISSUE next cycle; o_types in ISSUE is the registered pressed type.
REQ-016 Simultaneous light and heavy press events SHALL issue HEAVY.
REQ-017 ISSUE SHALL last exactly one cycle, with o_types non-STANDBY only in ISSUE, and then go to COOLDOWN with the counter loaded for LIGHT_COOLDOWN or HEAVY_COOLDOWN per the issued type.
REQ-018 COOLDOWN SHALL last exactly the loaded number of cycles, then return to IDLE; so the earliest next ISSUE is cooldown+2 cycles after the previous ISSUE.
REQ-019 A cooldown parameter of 0 SHALL go ISSUE to IDLE directly.
REQ-020 Press events in COOLDOWN SHALL be discarded unless ATTACK_QUEUE_EN is defined.
REQ-021 o_attack_count SHALL increment once per ISSUE cycle and wrap 255 to 0.
REQ-022 i_game_active low SHALL force IDLE next cycle, aborting ISSUE/COOLDOWN, forcing o_types to STANDBY and clearing any queued press; o_attack_count SHALL be held.
REQ-023 The debouncers SHALL keep running while i_game_active is low, so a button held across match start does not issue an attack.

Reset
REQ-024 Asserting i_reset low SHALL immediately set the state to IDLE, o_types to STANDBY, o_busy to 0, o_attack_count to 0, the cooldown counter to 0, the synchronizers and debounced levels to 0, and the queue to empty.
REQ-025 Reset deassertion SHALL be synchronized to i_clk, and the first press event SHALL be possible only after a full debounce.

Configuration
REQ-026 With macro ATTACK_QUEUE_EN defined, a press during COOLDOWN SHALL be held in a one-entry queue.
REQ-027 The first queued type SHALL be kept, except that a later HEAVY SHALL replace a queued LIGHT.
REQ-028 The queued press SHALL cause COOLDOWN to go directly to ISSUE, replacing IDLE, and the queue SHALL empty in that ISSUE.
REQ-029 Without ATTACK_QUEUE_EN, no queue logic SHALL exist and REQ-020 discard behaviour SHALL apply.

Structure
REQ-030 A shared package game_pkg SHALL hold the attack type codes STANDBY/LIGHT/HEAVY and the attack state codes NO_HIT/CRITICAL/NORMAL/MISS, shared with game mechanics.
REQ-031 Sub-module btn_debounce (synchronizer, debouncer and rising-edge detect; parameter DEBOUNCE_CYCLES) SHALL be instantiated once per button.

Verification
REQ-032 With defaults, after reset, i_game_active=1 and i_btn_light held high for 20 cycles, the bench SHALL see o_types=1 for exactly one cycle, 7 cycles after the first sampled high, then o_busy=1 for 9 cycles and o_attack_count=1.
REQ-033 Light and heavy rising in the same cycle SHALL give a single o_types=2 issue followed by 16 COOLDOWN cycles.
REQ-034 A button glitching high for 3 cycles (< DEBOUNCE_CYCLES) SHALL cause no issue and o_attack_count to stay 0.
REQ-035 A light press 3 cycles into a HEAVY cooldown SHALL be dropped without the macro; with ATTACK_QUEUE_EN it SHALL give o_types=1 in the cycle immediately after the 16th COOLDOWN cycle.
REQ-036 i_game_active dropped mid-COOLDOWN, and i_reset asserted asynchronously mid-ISSUE, SHALL each make o_types=0 and o_busy=0, and reset SHALL also clear o_attack_count to 0.
REQ-037 256 issued attacks SHALL wrap o_attack_count to 0.
